// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch front end.
// Issues one request at a time from an internal fetch PC, captures the
// returning word into an instruction register, and handles redirects
// (including squashing an in-flight response and trapping misaligned
// targets).
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_fetch_en,
   input  logic        i_redirect_valid,
   input  logic [31:0] i_redirect_pc,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] instr_o,
   output logic        instr_valid_o,
   input  logic        i_instr_ack,
   output logic [31:0] pc_o,
   output logic        misaligned_o
);

   localparam int unsigned XLEN      = 32;
   localparam int unsigned INSTR_BYT = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_WAIT  = 2'd2,
      S_VALID = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [XLEN-1:0]   r_fetch_pc;
   logic [XLEN-1:0]   r_instr;
   logic [XLEN-1:0]   r_pc;
   logic              r_instr_valid;
   logic              r_misaligned;
   logic              r_kill;
   logic              r_imem_req;

   logic [XLEN-1:0]   w_fetch_pc_nxt;
   logic [XLEN-1:0]   w_instr_nxt;
   logic [XLEN-1:0]   w_pc_nxt;
   logic              w_instr_valid_nxt;
   logic              w_misaligned_nxt;
   logic              w_kill_nxt;
   logic              w_imem_req_nxt;

   logic              w_redir_ok;
   logic              w_redir_bad;
   logic [XLEN-1:0]   w_pc_inc;

   // Classify the redirect by alignment of its target
   assign w_redir_ok  = i_redirect_valid & (i_redirect_pc[1:0] == 2'b00);
   assign w_redir_bad = i_redirect_valid & (i_redirect_pc[1:0] != 2'b00);

   // Sequential PC increment; wraps naturally at 2^32
   assign w_pc_inc = r_fetch_pc + XLEN'(INSTR_BYT);

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; redirects outrank ack, gnt and rvalid
   always_comb begin
      w_state_nxt = r_state;
      if (w_redir_bad) begin
         w_state_nxt = S_IDLE;
      end else if (w_redir_ok) begin
         case (r_state)
            S_IDLE:  w_state_nxt = S_IDLE;
            S_VALID: w_state_nxt = S_IDLE;
            // Granted in the redirect cycle: the response still has to drain
            S_REQ:   w_state_nxt = i_imem_gnt ? S_WAIT : S_REQ;
            S_WAIT:  w_state_nxt = i_imem_rvalid ? S_IDLE : S_WAIT;
            default: w_state_nxt = S_IDLE;
         endcase
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_fetch_en && !r_misaligned) begin
                  w_state_nxt = S_REQ;
               end
            end
            S_REQ: begin
               if (i_imem_gnt) begin
                  w_state_nxt = S_WAIT;
               end
            end
            S_WAIT: begin
               if (i_imem_rvalid) begin
                  w_state_nxt = r_kill ? S_IDLE : S_VALID;
               end
            end
            S_VALID: begin
               if (i_instr_ack) begin
                  w_state_nxt = i_fetch_en ? S_REQ : S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Output / datapath next values
   always_comb begin
      w_fetch_pc_nxt    = r_fetch_pc;
      w_instr_nxt       = r_instr;
      w_pc_nxt          = r_pc;
      w_instr_valid_nxt = r_instr_valid;
      w_misaligned_nxt  = r_misaligned;
      w_kill_nxt        = r_kill;
      w_imem_req_nxt    = (w_state_nxt == S_REQ);

      if (w_redir_bad) begin
         // Fetch PC left untouched; fetching blocked until an aligned redirect
         w_misaligned_nxt  = 1'b1;
         w_instr_valid_nxt = 1'b0;
         w_kill_nxt        = 1'b0;
      end else if (w_redir_ok) begin
         w_misaligned_nxt  = 1'b0;
         w_fetch_pc_nxt    = i_redirect_pc;
         w_instr_valid_nxt = 1'b0;
         // Squash a response that is still in flight
         case (r_state)
            S_REQ:   w_kill_nxt = i_imem_gnt;
            S_WAIT:  w_kill_nxt = ~i_imem_rvalid;
            default: w_kill_nxt = 1'b0;
         endcase
      end else begin
         case (r_state)
            S_WAIT: begin
               if (i_imem_rvalid) begin
                  if (r_kill) begin
                     w_kill_nxt = 1'b0;
                  end else begin
                     w_instr_nxt       = i_imem_rdata;
                     w_pc_nxt          = r_fetch_pc;
                     w_fetch_pc_nxt    = w_pc_inc;
                     w_instr_valid_nxt = 1'b1;
                  end
               end
            end
            S_VALID: begin
               if (i_instr_ack) begin
                  w_instr_valid_nxt = 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Datapath and output registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_fetch_pc    <= RESET_PC;
         r_instr       <= '0;
         r_pc          <= '0;
         r_instr_valid <= 1'b0;
         r_misaligned  <= 1'b0;
         r_kill        <= 1'b0;
         r_imem_req    <= 1'b0;
      end else begin
         r_fetch_pc    <= w_fetch_pc_nxt;
         r_instr       <= w_instr_nxt;
         r_pc          <= w_pc_nxt;
         r_instr_valid <= w_instr_valid_nxt;
         r_misaligned  <= w_misaligned_nxt;
         r_kill        <= w_kill_nxt;
         r_imem_req    <= w_imem_req_nxt;
      end
   end

   assign imem_req_o    = r_imem_req;
   assign imem_addr_o   = r_fetch_pc;
   assign instr_o       = r_instr;
   assign pc_o          = r_pc;
   assign instr_valid_o = r_instr_valid;
   assign misaligned_o  = r_misaligned;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a scoreboard of expected
// {instr, pc} pairs, popped whenever instr_valid_o rises.
`timescale 1ns/1ps
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_fetch_en;
   logic        i_redirect_valid;
   logic [31:0] i_redirect_pc;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        i_imem_gnt;
   logic        i_imem_rvalid;
   logic [31:0] i_imem_rdata;
   logic [31:0] instr_o;
   logic        instr_valid_o;
   logic        i_instr_ack;
   logic [31:0] pc_o;
   logic        misaligned_o;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } sb_t;

   sb_t sb_q[$];
   int  n_tests = 0;
   int  n_fail  = 0;
   logic prev_valid = 1'b0;

   fetch_unit #(.RESET_PC(RESET_PC)) dut (
      .i_clk            (i_clk),
      .i_rst            (i_rst),
      .i_fetch_en       (i_fetch_en),
      .i_redirect_valid (i_redirect_valid),
      .i_redirect_pc    (i_redirect_pc),
      .imem_req_o       (imem_req_o),
      .imem_addr_o      (imem_addr_o),
      .i_imem_gnt       (i_imem_gnt),
      .i_imem_rvalid    (i_imem_rvalid),
      .i_imem_rdata     (i_imem_rdata),
      .instr_o          (instr_o),
      .instr_valid_o    (instr_valid_o),
      .i_instr_ack      (i_instr_ack),
      .pc_o             (pc_o),
      .misaligned_o     (misaligned_o)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Scoreboard: every rising instr_valid_o must match the oldest expected entry
   always @(negedge i_clk) begin
      if (instr_valid_o && !prev_valid) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_valid", 32'(instr_valid_o), 32'd0);
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            check("sb_instr", instr_o, e.instr);
            check("sb_pc", pc_o, e.pc);
         end
      end
      prev_valid = instr_valid_o;
   end

   task automatic wait_req();
      for (int i = 0; i < 20 && !imem_req_o; i++) tick();
      check("req_seen", 32'(imem_req_o), 32'd1);
   endtask

   task automatic redirect(input logic [31:0] tgt);
      i_redirect_valid = 1'b1;
      i_redirect_pc    = tgt;
      tick();
      i_redirect_valid = 1'b0;
   endtask

   // One complete fetch: request, optional grant stall, response, ack
   task automatic fetch_one(input logic [31:0] exp_pc, input logic [31:0] data,
                            input int gnt_delay, input logic en_after);
      i_fetch_en = 1'b1;
      wait_req();
      check("req_addr", imem_addr_o, exp_pc);
      for (int i = 0; i < gnt_delay; i++) begin
         tick();
         check("stall_req", 32'(imem_req_o), 32'd1);
         check("stall_addr", imem_addr_o, exp_pc);
      end
      i_imem_gnt = 1'b1;
      tick();
      i_imem_gnt = 1'b0;
      check("wait_noreq", 32'(imem_req_o), 32'd0);
      check("wait_novalid", 32'(instr_valid_o), 32'd0);
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = data;
      sb_q.push_back('{instr: data, pc: exp_pc});
      tick();
      i_imem_rvalid = 1'b0;
      check("valid_set", 32'(instr_valid_o), 32'd1);
      check("valid_noreq", 32'(imem_req_o), 32'd0);
      i_fetch_en  = en_after;
      i_instr_ack = 1'b1;
      tick();
      i_instr_ack = 1'b0;
      check("ack_clr", 32'(instr_valid_o), 32'd0);
      check("next_addr", imem_addr_o, exp_pc + 32'd4);
      check("next_req", 32'(imem_req_o), 32'(en_after));
   endtask

   initial begin
      i_rst = 1'b1; i_fetch_en = 1'b0; i_redirect_valid = 1'b0; i_redirect_pc = '0;
      i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = '0; i_instr_ack = 1'b0;
      tick(); tick();
      check("rst_req", 32'(imem_req_o), 32'd0);
      check("rst_addr", imem_addr_o, RESET_PC);
      check("rst_instr", instr_o, 32'd0);
      check("rst_pc", pc_o, 32'd0);
      check("rst_valid", 32'(instr_valid_o), 32'd0);
      check("rst_mis", 32'(misaligned_o), 32'd0);
      i_rst = 1'b0;
      tick();

      // First fetch from RESET_PC, then continue straight into a stalled grant
      fetch_one(RESET_PC, 32'h0050_0093, 0, 1'b1);
      check("first_instr", instr_o, 32'h0050_0093);
      check("first_pc", pc_o, RESET_PC);
      fetch_one(32'h0000_0004, 32'h1111_1111, 3, 1'b0);
      tick();
      check("idle_noreq", 32'(imem_req_o), 32'd0);

      // Redirect while waiting: response dropped
      i_fetch_en = 1'b1;
      wait_req();
      i_imem_gnt = 1'b1; tick(); i_imem_gnt = 1'b0;
      i_fetch_en = 1'b0;
      redirect(32'h0000_0100);
      check("wr_addr", imem_addr_o, 32'h0000_0100);
      check("wr_novalid", 32'(instr_valid_o), 32'd0);
      i_imem_rvalid = 1'b1; i_imem_rdata = 32'hDEAD_BEEF; tick(); i_imem_rvalid = 1'b0;
      check("wr_drop_valid", 32'(instr_valid_o), 32'd0);
      check("wr_drop_addr", imem_addr_o, 32'h0000_0100);
      tick();
      check("wr_idle", 32'(imem_req_o), 32'd0);
      fetch_one(32'h0000_0100, 32'h2222_2222, 1, 1'b0);

      // Redirect with grant in the same cycle: squashed response
      i_fetch_en = 1'b1;
      wait_req();
      i_fetch_en = 1'b0;
      i_imem_gnt = 1'b1;
      redirect(32'h0000_0300);
      i_imem_gnt = 1'b0;
      check("rg_noreq", 32'(imem_req_o), 32'd0);
      check("rg_addr", imem_addr_o, 32'h0000_0300);
      tick();
      i_imem_rvalid = 1'b1; i_imem_rdata = 32'hBAD0_0001; tick(); i_imem_rvalid = 1'b0;
      check("rg_drop_valid", 32'(instr_valid_o), 32'd0);
      check("rg_drop_addr", imem_addr_o, 32'h0000_0300);
      fetch_one(32'h0000_0300, 32'h3333_3333, 0, 1'b0);

      // Redirect coincident with rvalid
      i_fetch_en = 1'b1;
      wait_req();
      i_imem_gnt = 1'b1; tick(); i_imem_gnt = 1'b0;
      i_fetch_en = 1'b0;
      i_imem_rvalid = 1'b1; i_imem_rdata = 32'hBAD0_0002;
      redirect(32'h0000_0400);
      i_imem_rvalid = 1'b0;
      check("rv_novalid", 32'(instr_valid_o), 32'd0);
      check("rv_addr", imem_addr_o, 32'h0000_0400);
      tick();
      check("rv_idle", 32'(imem_req_o), 32'd0);

      // Redirect in REQ without grant: new address presented, still requesting
      i_fetch_en = 1'b1;
      wait_req();
      redirect(32'h0000_0500);
      check("rq_req", 32'(imem_req_o), 32'd1);
      check("rq_addr", imem_addr_o, 32'h0000_0500);
      fetch_one(32'h0000_0500, 32'h4444_4444, 0, 1'b0);

      // Misaligned redirect blocks fetching until an aligned one
      redirect(32'h0000_0102);
      check("mis_set", 32'(misaligned_o), 32'd1);
      check("mis_addr", imem_addr_o, 32'h0000_0504);
      i_fetch_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("mis_noreq", 32'(imem_req_o), 32'd0);
      end
      redirect(32'h0000_0200);
      check("mis_clr", 32'(misaligned_o), 32'd0);
      fetch_one(32'h0000_0200, 32'h5555_5555, 0, 1'b0);

      // Address wrap at the top of the space
      redirect(32'hFFFF_FFFC);
      fetch_one(32'hFFFF_FFFC, 32'h6666_6666, 0, 1'b0);
      check("wrap_pc", pc_o, 32'hFFFF_FFFC);
      check("wrap_mis", 32'(misaligned_o), 32'd0);

      // Asynchronous reset while a response is outstanding
      redirect(32'h0000_0600);
      i_fetch_en = 1'b1;
      wait_req();
      i_imem_gnt = 1'b1; tick(); i_imem_gnt = 1'b0;
      i_fetch_en = 1'b0;
      #2;
      i_rst = 1'b1;
      i_imem_rvalid = 1'b1; i_imem_rdata = 32'hBAD0_0003;
      #1;
      check("ar_req", 32'(imem_req_o), 32'd0);
      check("ar_addr", imem_addr_o, RESET_PC);
      check("ar_instr", instr_o, 32'd0);
      check("ar_pc", pc_o, 32'd0);
      check("ar_valid", 32'(instr_valid_o), 32'd0);
      check("ar_mis", 32'(misaligned_o), 32'd0);
      tick();
      i_rst = 1'b0;
      tick();
      i_imem_rvalid = 1'b0;
      check("ar_post_valid", 32'(instr_valid_o), 32'd0);
      check("ar_post_req", 32'(imem_req_o), 32'd0);
      fetch_one(RESET_PC, 32'h7777_7777, 0, 1'b0);

      tick(); tick();
      check("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
